// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the CPU fetch
// port and the CPU load/store port. Data side has priority, bounded by a fetch
// anti-starvation limit. Define MEM_PORT_ARBITER_PERF_EN to add perf counters.

module mem_port_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned MEM_LAT      = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          i_clk,
   input  logic          i_reset_s,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_ack,
   output logic [DW-1:0] o_if_rdata,
   input  logic          i_d_req,
   input  logic          i_d_we,
   input  logic [AW-1:0] i_d_addr,
   input  logic [DW-1:0] i_d_wdata,
   output logic          o_d_ack,
   output logic [DW-1:0] o_d_rdata,
   output logic          o_mem_en,
   output logic          o_mem_read,
   output logic          o_mem_write,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
`ifdef MEM_PORT_ARBITER_PERF_EN
   output logic [31:0]   o_perf_conflicts,
   output logic [31:0]   o_perf_fetch_wait,
`endif
   output logic          o_busy
);

   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);
   localparam logic [2:0] LP_LAT   = 3'(MEM_LAT);

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_t;

   state_t        r_state;
   logic          r_owner_d;   // 1: data port owns the access, 0: fetch port
   logic          r_we;
   logic [3:0]    r_starve;
   logic [2:0]    r_wait;
   logic          r_if_ack;
   logic          r_d_ack;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          r_mem_en;
   logic          r_mem_read;
   logic          r_mem_write;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_busy;

   logic w_sel_data;
   logic w_sel_fetch;

   // Data wins unless fetch is pending and has been passed over too often
   assign w_sel_data  = i_d_req && ((r_starve < LP_LIMIT) || !i_if_req);
   assign w_sel_fetch = !w_sel_data && i_if_req;

   // Arbitration FSM with registered memory strobes, acks and read data
   always_ff @(posedge i_clk) begin
      if (i_reset_s) begin
         r_state     <= StIdle;
         r_owner_d   <= 1'b0;
         r_we        <= 1'b0;
         r_starve    <= '0;
         r_wait      <= '0;
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_mem_en    <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         // Strobes and acks are single-cycle pulses
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_sel_data) begin
                  r_owner_d   <= 1'b1;
                  r_we        <= i_d_we;
                  r_mem_addr  <= i_d_addr;
                  r_mem_wdata <= i_d_wdata;
                  r_mem_en    <= 1'b1;
                  r_mem_read  <= !i_d_we;
                  r_mem_write <= i_d_we;
                  r_busy      <= 1'b1;
                  r_state     <= StAccess;
                  if (!i_if_req) begin
                     r_starve <= '0;
                  end else if (r_starve < LP_LIMIT) begin
                     r_starve <= r_starve + 4'd1;
                  end
               end else if (w_sel_fetch) begin
                  r_owner_d   <= 1'b0;
                  r_we        <= 1'b0;
                  r_mem_addr  <= i_if_addr;
                  r_mem_en    <= 1'b1;
                  r_mem_read  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= StAccess;
                  r_starve    <= '0;
               end else begin
                  // No selection implies fetch is not requesting
                  r_starve <= '0;
               end
            end
            StAccess: begin
               if (r_we) begin
                  r_d_ack <= 1'b1;
                  r_state <= StDone;
               end else begin
                  r_wait  <= LP_LAT;
                  r_state <= StWait;
               end
            end
            StWait: begin
               r_wait <= r_wait - 3'd1;
               if (r_wait == 3'd1) begin
                  if (r_owner_d) begin
                     r_d_rdata <= i_mem_rdata;
                     r_d_ack   <= 1'b1;
                  end else begin
                     r_if_rdata <= i_mem_rdata;
                     r_if_ack   <= 1'b1;
                  end
                  r_state <= StDone;
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_if_ack    = r_if_ack;
   assign o_if_rdata  = r_if_rdata;
   assign o_d_ack     = r_d_ack;
   assign o_d_rdata   = r_d_rdata;
   assign o_mem_en    = r_mem_en;
   assign o_mem_read  = r_mem_read;
   assign o_mem_write = r_mem_write;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_busy      = r_busy;

`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [31:0] r_perf_conflicts;
   logic [31:0] r_perf_fetch_wait;

   // Saturating conflict and fetch-wait event counters
   always_ff @(posedge i_clk) begin
      if (i_reset_s) begin
         r_perf_conflicts  <= '0;
         r_perf_fetch_wait <= '0;
      end else begin
         if ((r_state == StIdle) && i_if_req && i_d_req && (r_perf_conflicts != '1)) begin
            r_perf_conflicts <= r_perf_conflicts + 32'd1;
         end
         if (i_if_req && !r_if_ack && (r_perf_fetch_wait != '1)) begin
            r_perf_fetch_wait <= r_perf_fetch_wait + 32'd1;
         end
      end
   end

   assign o_perf_conflicts  = r_perf_conflicts;
   assign o_perf_fetch_wait = r_perf_fetch_wait;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts each
// memory access and ack (cycle, owner, data); a monitor compares DUT outputs.

module tb_mem_port_arbiter;

   localparam int LAT = 3;
   localparam int LIM = 2;

   logic        clk;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic        if_ack, d_ack, mem_en, mem_read, mem_write, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [31:0] perf_conflicts, perf_fetch_wait;
`endif

   mem_port_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)
   ) dut (
      .i_clk       (clk),
      .i_reset_s   (rst),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_ack    (if_ack),
      .o_if_rdata  (if_rdata),
      .i_d_req     (d_req),
      .i_d_we      (d_we),
      .i_d_addr    (d_addr),
      .i_d_wdata   (d_wdata),
      .o_d_ack     (d_ack),
      .o_d_rdata   (d_rdata),
      .o_mem_en    (mem_en),
      .o_mem_read  (mem_read),
      .o_mem_write (mem_write),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
`ifdef MEM_PORT_ARBITER_PERF_EN
      .o_perf_conflicts  (perf_conflicts),
      .o_perf_fetch_wait (perf_fetch_wait),
`endif
      .o_busy      (busy)
   );

   typedef struct {int c; bit we; logic [31:0] addr; logic [31:0] data;} mexp_t;
   typedef struct {int c; bit isd; bit rd; logic [31:0] data;} aexp_t;
   typedef struct {int c; bit isd;} log_t;

   mexp_t mq[$];
   aexp_t aq[$];
   log_t  glog[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // model state
   int m_free = 0, m_starve = 0, busy_from = 1, busy_to = 0;
   logic [31:0] sh_mem  [64];
   logic [31:0] env_mem [64];
   logic [31:0] slot_d  [8];
   bit          slot_v  [8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Memory environment: writes land at mem_en, read data appears LAT cycles later
   initial begin
      int idx;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_en && mem_write) env_mem[mem_addr[7:2]] = mem_wdata;
         if (mem_en && mem_read) begin
            idx = (cyc + LAT) % 8;
            slot_v[idx] = 1'b1;
            slot_d[idx] = env_mem[mem_addr[7:2]];
         end
         idx = cyc % 8;
         if (slot_v[idx]) begin
            mem_rdata   = slot_d[idx];
            slot_v[idx] = 1'b0;
         end else begin
            mem_rdata = $urandom;
         end
      end
   end

   // Monitor: pops predictions whenever the DUT shows an access or an ack
   initial begin
      bit          prev_rst, armed, got, ex, ok;
      logic [31:0] er_if, er_d;
      mexp_t       me;
      aexp_t       ae;
      int          c;
      log_t        lg;
      prev_rst = 0; armed = 0; er_if = '0; er_d = '0;
      forever begin
         @(negedge clk);
         #2;
         c = cyc;
         if (prev_rst) begin
            armed = 1; er_if = '0; er_d = '0;
            ok = !(if_ack || d_ack || mem_en || mem_read || mem_write || busy) &&
                 mem_addr == 0 && mem_wdata == 0 && if_rdata == 0 && d_rdata == 0;
            chk(ok, "reset_outputs", {mem_addr[15:0], if_rdata[7:0], d_rdata[7:0]}, 0);
         end
         if (armed) begin
            got = mem_en;
            ex  = mq.size() > 0 && mq[0].c == c;
            if (got || ex) begin
               me = '{c: c, we: 0, addr: '0, data: '0};
               if (ex) me = mq.pop_front();
               ok = got && ex && mem_read == !me.we && mem_write == me.we &&
                    mem_addr == me.addr && (!me.we || mem_wdata == me.data);
               chk(ok, ex ? "mem_access" : "mem_unexpected", mem_addr, me.addr);
            end
            ok = !((mem_read || mem_write) && !mem_en) && !(mem_read && mem_write);
            chk(ok, "mem_qualifiers", {mem_en, mem_read, mem_write}, {mem_en, 2'b0});
            ex = aq.size() > 0 && aq[0].c == c;
            if (if_ack || d_ack || ex) begin
               ae = '{c: c, isd: 0, rd: 0, data: '0};
               if (ex) ae = aq.pop_front();
               ok = ex && (if_ack == !ae.isd) && (d_ack == ae.isd) &&
                    (!ae.rd || (ae.isd ? d_rdata : if_rdata) == ae.data);
               chk(ok, ex ? "ack" : "ack_unexpected",
                   ae.isd ? d_rdata : if_rdata, ae.data);
               if (ex && ae.rd) begin
                  if (ae.isd) er_d = ae.data;
                  else        er_if = ae.data;
               end
            end
            if (if_ack || d_ack) begin
               lg.c = c; lg.isd = d_ack;
               glog.push_back(lg);
            end
            chk(if_rdata == er_if, "if_rdata_hold", if_rdata, er_if);
            chk(d_rdata == er_d, "d_rdata_hold", d_rdata, er_d);
            chk(busy == (c >= busy_from && c <= busy_to), "busy", busy,
                (c >= busy_from && c <= busy_to));
         end
         prev_rst = rst;
      end
   end

   // Start of a cycle: requesters release their request on ack
   task automatic cyc_begin();
      @(negedge clk);
      if (if_ack) if_req = 1'b0;
      if (d_ack)  d_req  = 1'b0;
   endtask

   // Reference model: arbitration decision and timing for the current cycle
   task automatic cyc_end();
      int          c, ackc, idx;
      bit          sd, si, we;
      logic [31:0] addr;
      mexp_t       me;
      aexp_t       ae;
      c = cyc;
      if (rst) begin
         m_free = c + 1; m_starve = 0;
         while (mq.size() > 0 && mq[mq.size()-1].c > c) mq.delete(mq.size()-1);
         while (aq.size() > 0 && aq[aq.size()-1].c > c) aq.delete(aq.size()-1);
         if (busy_to > c) busy_to = c;
      end else if (c >= m_free) begin
         sd = d_req && (m_starve < LIM || !if_req);
         si = !sd && if_req;
         if (sd && if_req) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
         else              m_starve = 0;
         if (sd || si) begin
            we   = sd ? d_we : 1'b0;
            addr = sd ? d_addr : if_addr;
            idx  = int'(addr[7:2]);
            ackc = c + (we ? 2 : LAT + 2);
            me.c = c + 1; me.we = we; me.addr = addr; me.data = d_wdata;
            mq.push_back(me);
            ae.c = ackc; ae.isd = sd; ae.rd = !we; ae.data = sh_mem[idx];
            aq.push_back(ae);
            if (we) sh_mem[idx] = d_wdata;
            m_free = ackc + 1; busy_from = c + 1; busy_to = ackc;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         cyc_begin();
         cyc_end();
         n++;
      end while (!(!if_req && !d_req && cyc >= m_free) && n < 100);
      chk(n < 100, "drain_timeout", n, 100);
   endtask

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      env_mem[a[7:2]] = v;
      sh_mem[a[7:2]]  = v;
   endtask

   initial begin
      int          t0;
      logic [5:0]  pat;
      for (int i = 0; i < 64; i++) begin
         env_mem[i] = 32'hA500_0000 + 32'(i * 4);
         sh_mem[i]  = 32'hA500_0000 + 32'(i * 4);
      end
      for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
      rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;

      // reset held 2 cycles with both requests high
      repeat (2) begin cyc_begin(); rst = 1'b1; cyc_end(); end
      cyc_begin(); rst = 1'b0; if_req = 1'b0; d_req = 1'b0; cyc_end();
      drain();

      // lone fetch
      set_word(32'h10, 32'hDEADBEEF);
      glog.delete();
      cyc_begin(); if_req = 1'b1; if_addr = 32'h10; t0 = cyc; cyc_end();
      drain();
      chk(glog.size() == 1 && !glog[0].isd, "lone_fetch_acks", glog.size(), 1);
      chk(glog.size() > 0 && glog[0].c == t0 + LAT + 2, "lone_fetch_latency",
          glog.size() > 0 ? glog[0].c - t0 : -1, LAT + 2);
      chk(if_rdata == 32'hDEADBEEF, "lone_fetch_rdata", if_rdata, 32'hDEADBEEF);

      // lone store then load back
      glog.delete();
      cyc_begin(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      t0 = cyc; cyc_end();
      drain();
      chk(glog.size() == 1 && glog[0].isd && glog[0].c == t0 + 2, "lone_store_ack",
          glog.size() > 0 ? glog[0].c - t0 : -1, 2);
      chk(env_mem[16] == 32'h12345678, "store_mem_word", env_mem[16], 32'h12345678);
      cyc_begin(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; cyc_end();
      drain();
      chk(d_rdata == 32'h12345678, "store_readback", d_rdata, 32'h12345678);

      // simultaneous requests: data first, then fetch
      glog.delete();
      cyc_begin();
      if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      cyc_end();
      drain();
      chk(glog.size() == 2 && glog[0].isd && !glog[1].isd, "simultaneous_order",
          glog.size(), 2);

      // starvation limit: both held / re-requested, expect D,D,I,D,D,I
      glog.delete();
      pat = 6'b110110;
      for (int k = 0; k < 200 && glog.size() < 6; k++) begin
         cyc_begin();
         if (!if_req) begin if_req = 1'b1; if_addr = 32'($urandom_range(0, 63)) << 2; end
         if (!d_req) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'($urandom_range(0, 63)) << 2;
         end
         cyc_end();
      end
      drain();
      for (int i = 0; i < 6; i++) begin
         chk(glog.size() > i && glog[i].isd == pat[5-i], "starve_order",
             glog.size() > i ? 32'(glog[i].isd) : 32'hFFFF_FFFF, 32'(pat[5-i]));
      end

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         cyc_begin();
         if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = 32'($urandom_range(0, 63)) << 2;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = 32'($urandom_range(0, 63)) << 2; d_wdata = $urandom;
         end
         cyc_end();
      end
      drain();

      // reset during the second WAIT cycle of a fetch
      set_word(32'h30, 32'hCAFEF00D);
      cyc_begin(); if_req = 1'b1; if_addr = 32'h30; cyc_end();
      drain();
      glog.delete();
      cyc_begin(); if_req = 1'b1; if_addr = 32'h34; t0 = cyc; cyc_end();
      repeat (2) begin cyc_begin(); cyc_end(); end
      cyc_begin(); rst = 1'b1; if_req = 1'b0; cyc_end();
      cyc_begin(); rst = 1'b0; cyc_end();
      chk(!busy, "midreset_idle", busy, 0);
      repeat (6) begin cyc_begin(); cyc_end(); end
      chk(glog.size() == 0, "midreset_no_ack", glog.size(), 0);
      chk(if_rdata == 0, "midreset_rdata", if_rdata, 0);
      cyc_begin(); if_req = 1'b1; if_addr = 32'h30; t0 = cyc; cyc_end();
      drain();
      chk(glog.size() == 1 && glog[0].c == t0 + LAT + 2, "fresh_fetch_ack",
          glog.size(), 1);
      chk(if_rdata == 32'hCAFEF00D, "fresh_fetch_rdata", if_rdata, 32'hCAFEF00D);

      repeat (4) begin cyc_begin(); cyc_end(); end
      chk(mq.size() == 0, "mem_queue_empty", mq.size(), 0);
      chk(aq.size() == 0, "ack_queue_empty", aq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
